// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control FSM with memory-handshake timeout trap.
// Define MULTICYCLE_JALR_EN to enable the JALR state; otherwise JALR traps.
module multicycle_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [3:0] ALUControl,
    output logic       trap,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
        S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
        S_ALUWB = 4'd8, S_BEQ = 4'd9, S_JAL = 4'd10, S_JALR = 4'd11,
        S_TRAP = 4'd12
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010,
                           ALU_OR  = 4'b0011, ALU_XOR = 4'b0100, ALU_SLT = 4'b0101,
                           ALU_SLL = 4'b0110, ALU_SRL = 4'b0111, ALU_SRA = 4'b1111;

    // Counter never passes TIMEOUT-1 outside TRAP: the next wait cycle traps.
    localparam int         CW        = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_wait_cnt;
    logic            w_waiting;
    logic            w_timeout;
    logic [3:0]      w_alu_dec;
    logic            w_pc_write;
    logic            w_ir_write;
    logic            w_mem_write;
    logic            w_reg_write;

    assign w_waiting = (r_state inside {S_FETCH, S_MEMREAD, S_MEMWRITE}) && !mem_ready;
    assign w_timeout = w_waiting && (r_wait_cnt == WAIT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) r_wait_cnt <= '0;
            else if (w_waiting)    r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:    if (mem_ready) w_next = S_DECODE;
                        else if (w_timeout) w_next = S_TRAP;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_RTYPE:          w_next = S_EXECR;
                    OP_ITYPE:          w_next = S_EXECI;
                    OP_BRANCH:         w_next = S_BEQ;
                    OP_JAL:            w_next = S_JAL;
`ifdef MULTICYCLE_JALR_EN
                    OP_JALR:           w_next = S_JALR;
`endif
                    default:           w_next = S_TRAP;
                endcase
            end
            S_MEMADR:   w_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) w_next = S_MEMWB;
                        else if (w_timeout) w_next = S_TRAP;
            S_MEMWRITE: if (mem_ready) w_next = S_FETCH;
                        else if (w_timeout) w_next = S_TRAP;
            S_MEMWB, S_ALUWB, S_BEQ: w_next = S_FETCH;
            S_EXECR, S_EXECI, S_JAL: w_next = S_ALUWB;
`ifdef MULTICYCLE_JALR_EN
            S_JALR:     w_next = S_ALUWB;
`endif
            S_TRAP:     w_next = S_TRAP;
            default:    w_next = S_TRAP;
        endcase
    end

    // SUB only for R-type; the I-type funct7_5 bit is immediate data except for shifts.
    always_comb begin
        w_alu_dec = ALU_ADD;
        case (funct3)
            3'b000: w_alu_dec = (op[5] && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b001: w_alu_dec = ALU_SLL;
            3'b010: w_alu_dec = ALU_SLT;
            3'b011: w_alu_dec = ALU_SLT;
            3'b100: w_alu_dec = ALU_XOR;
            3'b101: w_alu_dec = funct7_5 ? ALU_SRA : ALU_SRL;
            3'b110: w_alu_dec = ALU_OR;
            3'b111: w_alu_dec = ALU_AND;
            default: w_alu_dec = ALU_ADD;
        endcase
    end

    always_comb begin
        ImmSrc = 3'b000;
        case (op)
            OP_STORE:        ImmSrc = 3'b001;
            OP_BRANCH:       ImmSrc = 3'b010;
            OP_JAL:          ImmSrc = 3'b011;
            OP_LUI, OP_AUIPC: ImmSrc = 3'b100;
            default:         ImmSrc = 3'b000;
        endcase
    end

    always_comb begin
        w_pc_write  = 1'b0;
        w_ir_write  = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        AdrSrc      = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ALUControl  = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                w_ir_write = mem_ready;
                w_pc_write = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                w_mem_write = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc   = 2'b01;
                w_reg_write = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = w_alu_dec;
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = w_alu_dec;
            end
            S_ALUWB: w_reg_write = 1'b1;
            S_BEQ: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                w_pc_write = (funct3 == 3'b000 && zero) || (funct3 == 3'b001 && !zero);
            end
            S_JAL: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                w_pc_write = 1'b1;
            end
`ifdef MULTICYCLE_JALR_EN
            S_JALR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ResultSrc  = 2'b10;
                w_pc_write = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Write strobes are forced low for as long as reset is held.
    assign PCWrite  = w_pc_write  & ~rst;
    assign IRWrite  = w_ir_write  & ~rst;
    assign MemWrite = w_mem_write & ~rst;
    assign RegWrite = w_reg_write & ~rst;
    assign trap     = (r_state == S_TRAP);
    assign state_o  = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench: each instruction expands into an expected per-cycle state trace
// built from its opcode path and chosen memory stall counts, then is replayed on the DUT.
module tb_multicycle_ctrl;

    localparam int TO = 4;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
                           S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
                           S_ALUWB = 4'd8, S_BEQ = 4'd9, S_JAL = 4'd10, S_JALR = 4'd11,
                           S_TRAP = 4'd12;

    localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                           OP_I = 7'b0010011, OP_B = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;
    logic       trap;
    logic [3:0] state_o;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [3:0] st;
        bit         mr;
    } ent_t;
    ent_t q[$];

    multicycle_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7_5(funct7_5),
        .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .trap(trap), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_alu(input logic [6:0] o, input logic [2:0] f3, input logic f75);
        case (f3)
            3'b000:  return (o == OP_R && f75) ? 4'b0001 : 4'b0000;
            3'b001:  return 4'b0110;
            3'b010:  return 4'b0101;
            3'b011:  return 4'b0101;
            3'b100:  return 4'b0100;
            3'b101:  return f75 ? 4'b1111 : 4'b0111;
            3'b110:  return 4'b0011;
            default: return 4'b0010;
        endcase
    endfunction

    function automatic logic [2:0] exp_imm(input logic [6:0] o);
        if (o == OP_SW)                    return 3'b001;
        if (o == OP_B)                     return 3'b010;
        if (o == OP_JAL)                   return 3'b011;
        if (o == OP_LUI || o == OP_AUIPC)  return 3'b100;
        return 3'b000;
    endfunction

    task automatic check_cycle(input logic [3:0] st, input bit in_rst);
        logic pcw = 1'b0, irw = 1'b0, mw = 1'b0, rw = 1'b0;
        if (!in_rst) begin
            if (st == S_FETCH)                   begin pcw = mem_ready; irw = mem_ready; end
            if (st == S_MEMWRITE)                mw = 1'b1;
            if (st == S_MEMWB || st == S_ALUWB)  rw = 1'b1;
            if (st == S_BEQ) pcw = (funct3 == 3'b000 && zero) || (funct3 == 3'b001 && !zero);
            if (st == S_JAL || st == S_JALR)     pcw = 1'b1;
        end
        check("state_o", 32'(state_o), 32'(st));
        check("PCWrite", 32'(PCWrite), 32'(pcw));
        check("IRWrite", 32'(IRWrite), 32'(irw));
        check("MemWrite", 32'(MemWrite), 32'(mw));
        check("RegWrite", 32'(RegWrite), 32'(rw));
        check("trap", 32'(trap), 32'(st == S_TRAP));
        check("ImmSrc", 32'(ImmSrc), 32'(exp_imm(op)));
        case (st)
            S_FETCH: begin
                check("FETCH.AdrSrc", 32'(AdrSrc), 32'd0);
                check("FETCH.ALUSrcA", 32'(ALUSrcA), 32'd0);
                check("FETCH.ALUSrcB", 32'(ALUSrcB), 32'd2);
                check("FETCH.ALUControl", 32'(ALUControl), 32'd0);
                check("FETCH.ResultSrc", 32'(ResultSrc), 32'd2);
            end
            S_DECODE: begin
                check("DECODE.ALUSrcA", 32'(ALUSrcA), 32'd1);
                check("DECODE.ALUSrcB", 32'(ALUSrcB), 32'd1);
                check("DECODE.ALUControl", 32'(ALUControl), 32'd0);
            end
            S_MEMREAD, S_MEMWRITE: check("MEM.AdrSrc", 32'(AdrSrc), 32'd1);
            S_MEMWB:  check("MEMWB.ResultSrc", 32'(ResultSrc), 32'd1);
            S_ALUWB:  check("ALUWB.ResultSrc", 32'(ResultSrc), 32'd0);
            S_EXECR, S_EXECI: check("EXEC.ALUControl", 32'(ALUControl), 32'(exp_alu(op, funct3, funct7_5)));
            S_BEQ:    check("BEQ.ALUControl", 32'(ALUControl), 32'd1);
            S_JAL: begin
                check("JAL.ALUSrcA", 32'(ALUSrcA), 32'd1);
                check("JAL.ALUSrcB", 32'(ALUSrcB), 32'd2);
                check("JAL.ResultSrc", 32'(ResultSrc), 32'd0);
            end
            S_JALR: begin
                check("JALR.ALUSrcA", 32'(ALUSrcA), 32'd2);
                check("JALR.ALUSrcB", 32'(ALUSrcB), 32'd1);
                check("JALR.ALUControl", 32'(ALUControl), 32'd0);
                check("JALR.ResultSrc", 32'(ResultSrc), 32'd2);
            end
            default: ;
        endcase
    endtask

    task automatic step(input logic [3:0] st, input bit mr);
        mem_ready = mr;
        @(negedge clk);
        check_cycle(st, 1'b0);
        @(posedge clk);
        #1;
    endtask

    // Two-edge reset with mem_ready high: strobes must stay low throughout.
    task automatic do_reset(input logic [3:0] prev);
        rst = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        check_cycle(prev, 1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_cycle(S_FETCH, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic push(input logic [3:0] st, input bit mr);
        ent_t e;
        e.st = st;
        e.mr = mr;
        q.push_back(e);
    endtask

    task automatic push_any(input logic [3:0] st);
        push(st, 1'($urandom_range(0, 1)));
    endtask

    // A wait phase: 'stalls' cycles without mem_ready; TO stalls or more means TRAP.
    task automatic push_wait(input logic [3:0] st, input int stalls, output bit trapped);
        trapped = (stalls >= TO);
        repeat (trapped ? TO : stalls) push(st, 1'b0);
        if (!trapped) push(st, 1'b1);
    endtask

    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input bit f75, input bit z,
                             input int sf, input int sm, input int abort_at);
        bit tr;
        q.delete();
        op = o;
        funct3 = f3;
        funct7_5 = f75;
        zero = z;
        push_wait(S_FETCH, sf, tr);
        if (!tr) begin
            push_any(S_DECODE);
            case (o)
                OP_LW: begin
                    push_any(S_MEMADR);
                    push_wait(S_MEMREAD, sm, tr);
                    if (!tr) push_any(S_MEMWB);
                end
                OP_SW: begin
                    push_any(S_MEMADR);
                    push_wait(S_MEMWRITE, sm, tr);
                end
                OP_R:   begin push_any(S_EXECR); push_any(S_ALUWB); end
                OP_I:   begin push_any(S_EXECI); push_any(S_ALUWB); end
                OP_B:   push_any(S_BEQ);
                OP_JAL: begin push_any(S_JAL); push_any(S_ALUWB); end
`ifdef MULTICYCLE_JALR_EN
                OP_JALR: begin push_any(S_JALR); push_any(S_ALUWB); end
`endif
                default: tr = 1'b1;
            endcase
        end
        if (tr) repeat (3) push_any(S_TRAP);
        for (int i = 0; i < q.size(); i++) begin
            if (i == abort_at) begin
                do_reset(q[i].st);
                return;
            end
            step(q[i].st, q[i].mr);
        end
        if (tr) do_reset(S_TRAP);
    endtask

    function automatic int pick_stall();
        int r = $urandom_range(0, 9);
        if (r == 0) return TO;
        if (r < 4)  return $urandom_range(1, TO - 1);
        return 0;
    endfunction

    logic [6:0] pool [9] = '{OP_LW, OP_SW, OP_R, OP_I, OP_B, OP_JAL, OP_JALR, OP_LUI, 7'b0000000};

    initial begin
        rst = 1'b1;
        op = OP_R;
        funct3 = 3'b000;
        funct7_5 = 1'b0;
        zero = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset(S_FETCH);

        run_instr(OP_R, 3'b000, 1'b0, 1'b0, 0, 0, -1);      // add
        run_instr(OP_R, 3'b000, 1'b1, 1'b0, 0, 0, -1);      // sub
        run_instr(OP_I, 3'b000, 1'b1, 1'b0, 0, 0, -1);      // addi, bit 30 set in imm
        run_instr(OP_I, 3'b101, 1'b1, 1'b0, 0, 0, -1);      // srai
        run_instr(OP_LW, 3'b010, 1'b0, 1'b0, 0, 3, -1);     // lw, 3 stalls in MEMREAD
        run_instr(OP_B, 3'b000, 1'b0, 1'b1, 0, 0, -1);      // beq taken
        run_instr(OP_B, 3'b001, 1'b0, 1'b1, 0, 0, -1);      // bne not taken
        run_instr(OP_LW, 3'b010, 1'b0, 1'b0, TO - 1, TO - 1, -1);  // ready on last allowed cycle
        run_instr(OP_R, 3'b000, 1'b0, 1'b0, TO, 0, -1);     // FETCH timeout, then reset
        run_instr(OP_JALR, 3'b000, 1'b0, 1'b0, 0, 0, -1);
        run_instr(OP_SW, 3'b010, 1'b0, 1'b0, 0, 2, 3);      // reset while in MEMWRITE
        run_instr(OP_JAL, 3'b000, 1'b0, 1'b0, 1, 0, -1);

        repeat (250) begin
            run_instr(pool[$urandom_range(0, 8)], 3'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      pick_stall(), pick_stall(),
                      ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 6)) : -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
